// File: rtl/ring_arbiter.sv
// ring_arbiter: round-robin one-hot grant with hold-until-release; watchdog under RING_ARBITER_TIMEOUT_EN
module ring_arbiter #(
  parameter int N        = 7,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           owner_release,
  output logic [N-1:0]   grant,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [IDW-1:0] ptr,
  output logic           timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d, ptr_q, ptr_d, sel;
  logic [7:0]     hold_cnt_q, hold_cnt_d;
  logic           timeout_q, timeout_d, found;
  // scan downward so the index closest to ptr overwrites the others
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % N]) begin
        found = 1'b1;
        sel   = IDW'((int'(ptr_q) + i) % N);
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d    = BUSY;
        grant_d    = {{(N-1){1'b0}}, 1'b1} << sel;
        gnt_id_d   = sel;
        ptr_d      = (sel == IDW'(N - 1)) ? '0 : sel + 1'b1;
        hold_cnt_d = '0;
      end
    end else if (owner_release) begin
      state_d = IDLE;
      grant_d = '0;
`ifdef RING_ARBITER_TIMEOUT_EN
    end else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
      state_d   = IDLE;
      grant_d   = '0;
      timeout_d = 1'b1;
`endif
    end else begin
      hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign grant     = grant_q;
  assign gnt_valid = (state_q == BUSY);
  assign gnt_id    = gnt_id_q;
  assign ptr       = ptr_q;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_ring_arbiter.sv
// tb_ring_arbiter: directed vectors for ring_arbiter (N=7, MAX_HOLD=15)
module tb_ring_arbiter;
  logic       clock = 1'b0;
  logic       reset, owner_release, gnt_valid, timeout;
  logic [6:0] req, grant;
  logic [2:0] gnt_id, ptr;
  int vectors = 0, miscompares = 0;

  ring_arbiter #(.N(7), .IDW(3), .MAX_HOLD(15)) dut (
    .clock(clock), .reset(reset), .req(req), .owner_release(owner_release),
    .grant(grant), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .ptr(ptr), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] g, input logic v,
                         input logic [2:0] id, input logic [2:0] p, input logic t);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    chk({tag, ".id"}, 32'(gnt_id), 32'(id));
    chk({tag, ".ptr"}, 32'(ptr), 32'(p));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    reset = 1'b1; req = 7'h7F; owner_release = 1'b0;
    tick(); chk_all("rst1", 7'h00, 0, 3'd0, 3'd0, 0);
    tick(); chk_all("rst2", 7'h00, 0, 3'd0, 3'd0, 0);
    reset = 1'b0;
    tick(); chk_all("first", 7'h01, 1, 3'd0, 3'd1, 0);
    req = 7'h00; owner_release = 1'b1;
    tick(); chk_all("rel0", 7'h00, 0, 3'd0, 3'd1, 0);
    tick(); chk_all("idle_rel_ignored", 7'h00, 0, 3'd0, 3'd1, 0);
    owner_release = 1'b0;
    req = 7'b0000100;
    tick(); chk_all("single", 7'h04, 1, 3'd2, 3'd3, 0);
    req = 7'h00;
    tick(); chk_all("single_hold", 7'h04, 1, 3'd2, 3'd3, 0);
    owner_release = 1'b1;
    tick(); chk_all("single_drop", 7'h00, 0, 3'd2, 3'd3, 0);
    owner_release = 1'b0;
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk_all("rst_again", 7'h00, 0, 3'd0, 3'd0, 0);
    req = 7'h7F;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_all($sformatf("rot%0d", k), 7'(1 << (k % 7)), 1, 3'(k % 7), 3'((k % 7 + 1) % 7), 0);
      owner_release = 1'b1;
      tick();
      chk_all($sformatf("rot%0d_gap", k), 7'h00, 0, 3'(k % 7), 3'((k % 7 + 1) % 7), 0);
      owner_release = 1'b0;
    end
    req = 7'b0010000;
    tick(); chk_all("to_ptr5", 7'h10, 1, 3'd4, 3'd5, 0);
    owner_release = 1'b1; req = 7'b0000011;
    tick(); chk_all("to_ptr5_drop", 7'h00, 0, 3'd4, 3'd5, 0);
    owner_release = 1'b0;
    tick(); chk_all("wrap_skip", 7'h01, 1, 3'd0, 3'd1, 0);
    owner_release = 1'b1;
    tick(); owner_release = 1'b0;
    chk_all("wrap_drop", 7'h00, 0, 3'd0, 3'd1, 0);
    req = 7'h7F;
    tick(); chk_all("hold_start", 7'h02, 1, 3'd1, 3'd2, 0);
    req = 7'h00;
`ifdef RING_ARBITER_TIMEOUT_EN
    for (int c = 1; c < 15; c++) begin
      tick(); chk_all($sformatf("wd_hold%0d", c), 7'h02, 1, 3'd1, 3'd2, 0);
    end
    tick(); chk_all("wd_fire", 7'h00, 0, 3'd1, 3'd2, 1);
    req = 7'h7F;
    tick(); chk_all("wd_regrant", 7'h04, 1, 3'd2, 3'd3, 0);
    owner_release = 1'b1;
    tick(); owner_release = 1'b0;
    chk_all("wd_real_rel", 7'h00, 0, 3'd2, 3'd3, 0);
    req = 7'b0010000;
    tick(); chk_all("mid_setup", 7'h10, 1, 3'd4, 3'd5, 0);
`else
    for (int c = 1; c <= 110; c++) begin
      tick();
      chk($sformatf("hold%0d.grant", c), 32'(grant), 32'h02);
      chk($sformatf("hold%0d.timeout", c), 32'(timeout), 32'h0);
    end
    owner_release = 1'b1;
    tick(); owner_release = 1'b0;
    chk_all("hold_drop", 7'h00, 0, 3'd1, 3'd2, 0);
    req = 7'b0010000;
    tick(); chk_all("mid_setup", 7'h10, 1, 3'd4, 3'd5, 0);
`endif
    reset = 1'b1;
    tick(); reset = 1'b0; req = 7'h00;
    chk_all("mid_busy_rst", 7'h00, 0, 3'd0, 3'd0, 0);
    tick(); chk_all("post_rst_idle", 7'h00, 0, 3'd0, 3'd0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ring_arbiter.md
# ring_arbiter

Round-robin arbiter/scheduler that shares one single-owner resource, such as a sequenced FSM datapath or its step-enable inputs, among `N` requesters. It scans requests from a rotating priority pointer and issues one registered one-hot grant. The grant is held until the owner releases it. An optional watchdog forcibly reclaims a grant that is held too long. The block sits between the requesting units and the shared sequencer.

## Interface
Parameters:
- `N`, 7, number of requesters (2..16)
- `IDW`, 3, width of index outputs; must equal ceil(log2 N)
- `MAX_HOLD`, 15, maximum grant length in cycles when the watchdog is compiled in (1..255)

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `req`  in  N  request vector, bit k = requester k
- `release`  in  1  current owner is done; only meaningful in BUSY
- `grant`  out  N  registered one-hot grant, all-zero when idle
- `gnt_valid`  out  1  high while any grant is asserted
- `gnt_id`  out  IDW  index of the current grantee; holds its last value when idle
- `ptr`  out  IDW  index given highest priority in the next search
- `timeout`  out  1  one-cycle pulse on a forced release; tied 0 without the macro

## Operation
- State machine has two states, IDLE and BUSY.
- **Reset (wins over all inputs):** state=IDLE, grant=0, gnt_valid=0, gnt_id=0, ptr=0, timeout=0, hold_cnt=0.
- **IDLE:**
  - Search indices ptr, ptr+1, …, wrapping mod N, and take the first k with req[k]=1.
  - If found: next cycle grant=1<<k, gnt_valid=1, gnt_id=k, ptr=(k+1) mod N, hold_cnt=0, state=BUSY.
  - If none: stay in IDLE with all registers unchanged.
  - `release` is ignored in IDLE.
- **BUSY:**
  - The grant is held regardless of `req`. A grantee dropping its request does not end the grant.
  - `release`=1: next cycle grant=0, gnt_valid=0, state=IDLE. gnt_id and ptr are unchanged.
  - `release`=0: hold_cnt increments, saturating at 255.
- A release and a new grant never occur in the same cycle. At least one IDLE cycle separates consecutive grants, so the peak grant rate is one every 2 cycles.
- Requests arriving while BUSY are only considered at the next IDLE search. The pointer has already advanced past the previous owner, which gives starvation-free rotation.
- ptr arithmetic: wrap (k+1)==N to 0. Values ≥N never occur.

## Timing
- Request-to-grant latency is 1 cycle: req sampled in IDLE at edge t, grant visible after edge t.
- Release-to-drop latency is 1 cycle.
- All outputs are registered; there are no combinational input-to-output paths.
- hold_cnt=0 in the first grant cycle and equals k in the k-th following BUSY cycle.

## Configuration
- Macro `RING_ARBITER_TIMEOUT_EN`.
- **Defined:**
  - In BUSY with hold_cnt==MAX_HOLD-1 and release=0, force a release.
  - Next cycle: grant=0, gnt_valid=0, state=IDLE, timeout=1 for exactly that cycle.
  - Net effect: a grant lasts exactly MAX_HOLD cycles.
  - A real release in the same cycle takes precedence, and timeout stays 0.
- **Undefined:** there is no watchdog, a grant is held until `release`, and `timeout` is constant 0.

## Test plan
- **Reset:** assert reset 2 cycles with req=all 1s. Outputs stay 0 during reset and ptr=0. After deassert, the first grant is gnt_id=0.
- **Single request:** req=7'b0000100 in IDLE at t. At t+1: grant=7'b0000100, gnt_id=2, gnt_valid=1, ptr=3. Pulse release at t+3. At t+4: grant=0, gnt_valid=0.
- **Rotation:** req=7'h7F held, release pulsed in every BUSY cycle. gnt_id sequence is 0,1,2,3,4,5,6,0 with one grant every 2 cycles.
- **Wrap and skip:** reach ptr=5, then req=7'b0000011. Result is gnt_id=0 (5 and 6 skipped) and ptr=1.
- **Watchdog** (macro defined, MAX_HOLD=15): grant with release held 0. Grant is high exactly 15 cycles, timeout pulses 1 cycle when the grant drops, then regrant follows rotation. With the macro undefined, the grant is held for 100+ cycles and timeout stays 0.
- **Reset mid-BUSY:** grant gnt_id=4, then assert reset. Next cycle: grant=0, gnt_valid=0, gnt_id=0, ptr=0, state IDLE.
